// File: rtl/uc_bcast_sched.sv
// Broadcast scheduler: pops unit-clause literals from a FWFT queue and hands each
// one to every enabled BCP engine, advancing only once all targets have accepted.
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 127
`endif

module uc_bcast_sched #(
  parameter int NUM_ENGINE = `NUM_ENGINE,
  parameter int LIT_W      = $clog2(`LIT_IDX_MAX) + 1,
  parameter int STALL_MAX  = 255,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    q_empty,
  input  logic signed [LIT_W-1:0] q_data,
  output logic                    q_pop,
  input  logic [NUM_ENGINE-1:0]   eng_enable,
  input  logic [NUM_ENGINE-1:0]   eng_full,
  output logic [NUM_ENGINE-1:0]   eng_valid,
  output logic signed [LIT_W-1:0] bcast_lit,
  input  logic                    conflict,
  input  logic                    restart,
  output logic                    halted,
  output logic                    idle,
  output logic                    stall_err,
  output logic [CNT_W-1:0]        bcast_count
);

  localparam int SC_W = ($clog2(STALL_MAX + 1) > 8) ? $clog2(STALL_MAX + 1) : 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BCAST = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t                  r_state;
  logic signed [LIT_W-1:0] r_lit;
  logic [NUM_ENGINE-1:0]   r_pending;
  logic [SC_W-1:0]         r_stall_cnt;
  logic                    r_stall_err;
  logic [CNT_W-1:0]        r_cnt;

  logic [NUM_ENGINE-1:0]   w_blocked;
  logic                    w_done;
  logic                    w_load;
  logic [SC_W-1:0]         w_stall_nxt;

  // Engines still pending after this cycle are exactly those that are full.
  assign w_blocked   = r_pending & eng_full;
  assign w_done      = (r_state == S_BCAST) && (w_blocked == '0);
  assign w_load      = !rst && !q_empty && !conflict && ((r_state == S_IDLE) || w_done);
  assign w_stall_nxt = (r_stall_cnt == '1) ? r_stall_cnt : r_stall_cnt + 1'b1;

  // Scheduler state, pending mask, stall watchdog and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lit       <= '0;
      r_pending   <= '0;
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
      r_cnt       <= '0;
    end else if (conflict) begin
      r_state   <= S_HALT;
      r_pending <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_IDLE;
        end
        S_BCAST: begin
          r_pending <= w_blocked;
          if (w_done) begin
            r_state <= S_IDLE;
            if (r_cnt != '1) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_stall_cnt <= w_stall_nxt;
            if (w_stall_nxt >= SC_W'(STALL_MAX)) begin
              r_stall_err <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (restart) begin
            r_state     <= S_IDLE;
            r_stall_err <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_pending <= '0;
        end
      endcase
      // A load overrides the completion path so back-to-back literals need no bubble.
      if (w_load) begin
        r_state     <= S_BCAST;
        r_lit       <= q_data;
        r_pending   <= eng_enable;
        r_stall_cnt <= '0;
      end
    end
  end

  assign q_pop       = w_load;
  assign eng_valid   = (r_state == S_BCAST) ? r_pending : '0;
  assign bcast_lit   = r_lit;
  assign halted      = (r_state == S_HALT);
  assign idle        = (r_state == S_IDLE) && q_empty;
  assign stall_err   = r_stall_err;
  assign bcast_count = r_cnt;

endmodule

// File: tb/tb_uc_bcast_sched.sv
// Directed bench for uc_bcast_sched: a queue model feeds the DUT, per-engine
// expected-literal queues are filled at push time and drained by a delivery monitor.
module tb_uc_bcast_sched;

  localparam int NE = 4;
  localparam int LW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          q_empty;
  logic [LW-1:0] q_data;
  logic          q_pop;
  logic [NE-1:0] eng_enable;
  logic [NE-1:0] eng_full;
  logic [NE-1:0] eng_valid;
  logic [LW-1:0] bcast_lit;
  logic          conflict;
  logic          restart;
  logic          halted;
  logic          idle;
  logic          stall_err;
  logic [CW-1:0] bcast_count;

  int n_vec = 0;
  int n_err = 0;

  logic [LW-1:0] qmem [0:63];
  int            q_rd = 0;
  int            q_wr = 0;
  logic [LW-1:0] exp_q [NE][$];
  int            rd_mark;

  always #5 clk = ~clk;

  uc_bcast_sched #(.NUM_ENGINE(NE), .LIT_W(LW), .STALL_MAX(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .q_empty(q_empty), .q_data(q_data), .q_pop(q_pop),
    .eng_enable(eng_enable), .eng_full(eng_full), .eng_valid(eng_valid),
    .bcast_lit(bcast_lit), .conflict(conflict), .restart(restart),
    .halted(halted), .idle(idle), .stall_err(stall_err), .bcast_count(bcast_count)
  );

  assign q_empty = (q_rd == q_wr);
  assign q_data  = q_empty ? '0 : qmem[q_rd[5:0]];

  always @(posedge clk) begin
    if (q_pop) q_rd <= q_rd + 1;
  end

  // Delivery monitor: a handshake is valid & ~full at the coming edge.
  always @(negedge clk) begin
    logic [LW-1:0] e;
    if (!rst && !conflict) begin
      for (int i = 0; i < NE; i++) begin
        if (eng_valid[i] && !eng_full[i]) begin
          n_vec++;
          if (exp_q[i].size() == 0) begin
            n_err++;
            $display("FAIL deliver_eng%0d: got lit %0d, expected no delivery", i, $signed(bcast_lit));
          end else begin
            e = exp_q[i].pop_front();
            if (bcast_lit !== e) begin
              n_err++;
              $display("FAIL deliver_eng%0d: got lit %0d, expected %0d", i, $signed(bcast_lit), $signed(e));
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [LW-1:0] lit, input logic [NE-1:0] mask);
    qmem[q_wr[5:0]] = lit;
    q_wr = q_wr + 1;
    for (int i = 0; i < NE; i++) if (mask[i]) exp_q[i].push_back(lit);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; eng_enable = 4'b1111; eng_full = 4'b0000; conflict = 1'b0; restart = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(eng_valid), 32'h0);
    chk("rst_lit", 32'(bcast_lit), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    chk("rst_stall", 32'(stall_err), 32'h0);
    chk("rst_count", 32'(bcast_count), 32'h0);
    chk("rst_pop", 32'(q_pop), 32'h0);

    // Two back-to-back literals, no backpressure
    push(8'sd3, 4'b1111); push(-8'sd5, 4'b1111);
    #1; chk("t1_pop0", 32'(q_pop), 32'h1);
    tick();
    chk("t1_valid0", 32'(eng_valid), 32'hF); chk("t1_lit0", 32'(bcast_lit), 32'h03);
    chk("t1_pop1", 32'(q_pop), 32'h1);
    tick();
    chk("t1_valid1", 32'(eng_valid), 32'hF); chk("t1_lit1", 32'(bcast_lit), 32'hFB);
    chk("t1_pop2", 32'(q_pop), 32'h0);
    tick();
    chk("t1_count", 32'(bcast_count), 32'd2); chk("t1_idle", 32'(idle), 32'h1);
    chk("t1_valid2", 32'(eng_valid), 32'h0);

    // Engine 2 full while +7 broadcasts; +9 follows on its acceptance
    eng_full = 4'b0100;
    push(8'sd7, 4'b1111); push(8'sd9, 4'b1111);
    #1; chk("t2_pop0", 32'(q_pop), 32'h1);
    tick();
    chk("t2_valid0", 32'(eng_valid), 32'hF); chk("t2_lit", 32'(bcast_lit), 32'h07);
    chk("t2_nopop0", 32'(q_pop), 32'h0);
    tick();
    chk("t2_hold0", 32'(eng_valid), 32'h4); chk("t2_nopop1", 32'(q_pop), 32'h0);
    tick();
    chk("t2_hold1", 32'(eng_valid), 32'h4);
    eng_full = 4'b0000;
    #1; chk("t2_pop1", 32'(q_pop), 32'h1);
    tick();
    chk("t2_valid1", 32'(eng_valid), 32'hF); chk("t2_lit9", 32'(bcast_lit), 32'h09);
    chk("t2_nostall", 32'(stall_err), 32'h0);
    tick(); tick();
    chk("t2_count", 32'(bcast_count), 32'd4); chk("t2_idle", 32'(idle), 32'h1);

    // Stall watchdog: engine 0 full past STALL_MAX=4 BCAST cycles
    eng_full = 4'b0001;
    push(8'sd11, 4'b1111);
    tick(); tick(); tick(); tick();
    chk("t3_stall3", 32'(stall_err), 32'h0);
    tick();
    chk("t3_stall4", 32'(stall_err), 32'h1); chk("t3_valid", 32'(eng_valid), 32'h1);
    eng_full = 4'b0000;
    tick();
    chk("t3_sticky", 32'(stall_err), 32'h1); chk("t3_count", 32'(bcast_count), 32'd5);
    chk("t3_valid_off", 32'(eng_valid), 32'h0);

    // Conflict with engines 1 and 3 still pending
    eng_full = 4'b1010;
    push(8'sd13, 4'b0101); push(8'sd15, 4'b1111);
    tick(); tick();
    chk("t4_pending", 32'(eng_valid), 32'hA);
    conflict = 1'b1;
    #1; chk("t4_nopop_c", 32'(q_pop), 32'h0);
    tick();
    conflict = 1'b0; eng_full = 4'b0000;
    #1;
    chk("t4_halted", 32'(halted), 32'h1); chk("t4_valid", 32'(eng_valid), 32'h0);
    chk("t4_count", 32'(bcast_count), 32'd5); chk("t4_nopop_h", 32'(q_pop), 32'h0);
    conflict = 1'b1; restart = 1'b1;
    tick();
    conflict = 1'b0;
    chk("t4_both", 32'(halted), 32'h1);
    tick();
    restart = 1'b0;
    #1;
    chk("t4_restart", 32'(halted), 32'h0); chk("t4_stall_clr", 32'(stall_err), 32'h0);
    chk("t4_pop", 32'(q_pop), 32'h1);
    tick();
    chk("t4_valid15", 32'(eng_valid), 32'hF); chk("t4_lit15", 32'(bcast_lit), 32'h0F);
    tick();
    chk("t4_count2", 32'(bcast_count), 32'd6);

    // No enabled engines: literals drain and are counted
    eng_enable = 4'b0000;
    rd_mark = q_rd;
    push(8'sd21, 4'b0000); push(8'sd22, 4'b0000); push(8'sd23, 4'b0000);
    tick();
    chk("t5_valid0", 32'(eng_valid), 32'h0); chk("t5_pop", 32'(q_pop), 32'h1);
    tick();
    chk("t5_valid1", 32'(eng_valid), 32'h0);
    tick(); tick();
    chk("t5_count", 32'(bcast_count), 32'd9); chk("t5_idle", 32'(idle), 32'h1);
    chk("t5_pops", 32'(q_rd - rd_mark), 32'd3);

    // Reset mid-broadcast with all engines full
    eng_enable = 4'b1111; eng_full = 4'b1111;
    push(8'sd31, 4'b0000); push(8'sd33, 4'b1111);
    tick();
    chk("t6_valid", 32'(eng_valid), 32'hF); chk("t6_lit", 32'(bcast_lit), 32'h1F);
    rst = 1'b1;
    rd_mark = q_rd;
    tick();
    #1;
    chk("t6_pop_rst", 32'(q_pop), 32'h0); chk("t6_valid_rst", 32'(eng_valid), 32'h0);
    chk("t6_lit_rst", 32'(bcast_lit), 32'h0); chk("t6_count_rst", 32'(bcast_count), 32'h0);
    chk("t6_halt_rst", 32'(halted), 32'h0); chk("t6_stall_rst", 32'(stall_err), 32'h0);
    chk("t6_idle_rst", 32'(idle), 32'h0);
    tick();
    chk("t6_no_pop", 32'(q_rd - rd_mark), 32'd0);
    rst = 1'b0; eng_full = 4'b0000;
    #1; chk("t6_pop", 32'(q_pop), 32'h1);
    tick();
    chk("t6_valid33", 32'(eng_valid), 32'hF); chk("t6_lit33", 32'(bcast_lit), 32'h21);
    tick();
    chk("t6_count", 32'(bcast_count), 32'd1); chk("t6_idle", 32'(idle), 32'h1);

    tick(); tick();
    for (int i = 0; i < NE; i++) chk("drain", 32'(exp_q[i].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
